// File: rtl/game_pkg.sv
// game_pkg: shared widths, bust limit, outcome codes and dealer FSM states
package game_pkg;
    localparam int SCORE_W = 6;
    localparam int CARD_W = 4;
    localparam logic [SCORE_W-1:0] BUST_LIMIT = 6'd21;
    typedef enum logic [1:0] {
        OUT_NONE   = 2'b00,
        OUT_PLAYER = 2'b01,
        OUT_DEALER = 2'b10,
        OUT_PUSH   = 2'b11
    } outcome_t;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, DONE} state_t;
endpackage

// File: rtl/dealer_sequencer_if.sv
// dealer_sequencer_if: card source handshake (card_req from dealer; card_valid and card from source)
interface dealer_sequencer_if;
    import game_pkg::*;
    logic              card_req;
    logic              card_valid;
    logic [CARD_W-1:0] card;
    modport master (output card_req, input card_valid, input card);
    modport slave  (input card_req, output card_valid, output card);
endinterface

// File: rtl/score_judge.sv
// score_judge: combinational round result from player_score and dealer_score into outcome
module score_judge
    import game_pkg::*;
(
    input  logic [SCORE_W-1:0] player_score,
    input  logic [SCORE_W-1:0] dealer_score,
    output outcome_t           outcome
);
    always_comb
        outcome = (player_score > BUST_LIMIT)   ? OUT_DEALER :
                  (dealer_score > BUST_LIMIT)   ? OUT_PLAYER :
                  (dealer_score > player_score) ? OUT_DEALER :
                  (dealer_score == player_score) ? OUT_PUSH : OUT_PLAYER;
endmodule

// File: rtl/dealer_sequencer.sv
// dealer_sequencer: dealer draw FSM; in clk rst_n start player_score, cif card handshake, out dealer_score cards_drawn busy done outcome
module dealer_sequencer
    import game_pkg::*;
#(
    parameter int STAND_AT  = 17,
    parameter int MAX_CARDS = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] player_score,
    dealer_sequencer_if.master cif,
    output logic [SCORE_W-1:0] dealer_score,
    output logic [2:0]         cards_drawn,
    output logic               busy,
    output logic               done,
    output logic [1:0]         outcome
);
    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         cnt_q, cnt_d;
    outcome_t           outcome_q, outcome_d, judged;
    logic               done_q, done_d;
    score_judge u_judge (
        .player_score (player_score),
        .dealer_score (score_q),
        .outcome      (judged)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            score_q   <= '0;
            cnt_q     <= '0;
            outcome_q <= OUT_NONE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            cnt_q     <= cnt_d;
            outcome_q <= outcome_d;
            done_q    <= done_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        cnt_d     = cnt_q;
        outcome_d = outcome_q;
        done_d    = state_q == DONE;
        case (state_q)
            IDLE: if (start) begin
                score_d   = '0;
                cnt_d     = '0;
                outcome_d = OUT_NONE;
                state_d   = (player_score > BUST_LIMIT) ? DONE : REQ;
            end
            REQ: state_d = WAIT;
            WAIT: if (cif.card_valid && cif.card != '0) begin
                score_d = score_q + SCORE_W'(cif.card);
                cnt_d   = cnt_q + 3'd1;
                state_d = CHECK;
            end
            CHECK: state_d = (score_q < SCORE_W'(STAND_AT) && cnt_q < 3'(MAX_CARDS)) ? REQ : DONE;
            DONE: begin
                outcome_d = judged;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        cif.card_req = state_q == REQ || state_q == WAIT;
        busy         = state_q != IDLE;
        done         = done_q;
        dealer_score = score_q;
        cards_drawn  = cnt_q;
        outcome      = outcome_q;
    end
endmodule

// File: tb/tb_dealer_sequencer.sv
// tb_dealer_sequencer: table-driven rounds plus hand-written corner sequences for dealer_sequencer
module tb_dealer_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cv = 1'b0;
    logic [3:0] card = 4'd0;
    logic [5:0] ps = 6'd0;
    logic       req[2];
    logic       busy[2];
    logic       dn[2];
    logic [5:0] ds[2];
    logic [2:0] cd[2];
    logic [1:0] oc[2];
    int n_tests = 0;
    int n_fail = 0;

    dealer_sequencer_if ci0();
    dealer_sequencer_if ci1();
    assign ci0.card_valid = cv;
    assign ci0.card = card;
    assign ci1.card_valid = cv;
    assign ci1.card = card;
    assign req[0] = ci0.card_req;
    assign req[1] = ci1.card_req;

    dealer_sequencer u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .player_score(ps), .cif(ci0),
        .dealer_score(ds[0]), .cards_drawn(cd[0]), .busy(busy[0]), .done(dn[0]), .outcome(oc[0])
    );
    dealer_sequencer #(.STAND_AT(17), .MAX_CARDS(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .player_score(ps), .cif(ci1),
        .dealer_score(ds[1]), .cards_drawn(cd[1]), .busy(busy[1]), .done(dn[1]), .outcome(oc[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        int             ps;
        int             n;
        logic [7:0][3:0] cards;
        int             e_score;
        int             e_cnt;
        int             e_out;
    } vec_t;
    vec_t tv[9];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        start = 1'b0;
        cv = 1'b0;
        card = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start(input int p);
        ps = 6'(p);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req(input int d);
        int t = 0;
        while (!req[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("req_seen", int'(req[d]), 1);
    endtask

    task automatic feed(input int d, input int c);
        wait_req(d);
        @(negedge clk);
        cv = 1'b1;
        card = 4'(c);
        @(negedge clk);
        cv = 1'b0;
        card = 4'd0;
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        while (!dn[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", int'(dn[d]), 1);
        @(negedge clk);
        chk("done_single", int'(dn[d]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        tv[0] = '{18, 2, 32'h0000_007A, 17, 2, 1};
        tv[1] = '{22, 0, 32'h0000_0000, 0, 0, 2};
        tv[2] = '{20, 3, 32'h0000_0D49, 26, 3, 1};
        tv[3] = '{19, 2, 32'h0000_009A, 19, 2, 3};
        tv[4] = '{18, 2, 32'h0000_009A, 19, 2, 2};
        tv[5] = '{21, 3, 32'h0000_056A, 21, 3, 3};
        tv[6] = '{10, 7, 32'h0222_2222, 14, 7, 2};
        tv[7] = '{17, 2, 32'h0000_00DA, 23, 2, 1};
        tv[8] = '{15, 3, 32'h0000_03D1, 17, 3, 2};

        #3;
        chk("rst_req", int'(req[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(dn[0]), 0);
        chk("rst_score", int'(ds[0]), 0);
        chk("rst_cnt", int'(cd[0]), 0);
        chk("rst_out", int'(oc[0]), 0);
        reset_all();

        for (int i = 0; i < 9; i++) begin
            reset_all();
            do_start(tv[i].ps);
            chk($sformatf("v%0d_req_lat", i), int'(req[0]), tv[i].ps <= 21 ? 1 : 0);
            chk($sformatf("v%0d_busy", i), int'(busy[0]), 1);
            for (int k = 0; k < tv[i].n; k++) feed(0, int'(tv[i].cards[k]));
            wait_done(0);
            chk($sformatf("v%0d_score", i), int'(ds[0]), tv[i].e_score);
            chk($sformatf("v%0d_cnt", i), int'(cd[0]), tv[i].e_cnt);
            chk($sformatf("v%0d_out", i), int'(oc[0]), tv[i].e_out);
            chk($sformatf("v%0d_idle", i), int'(busy[0]), 0);
        end

        reset_all();
        ps = 6'd22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bust_done_early", int'(dn[0]), 0);
        chk("bust_busy", int'(busy[0]), 1);
        chk("bust_req1", int'(req[0]), 0);
        @(negedge clk);
        chk("bust_done", int'(dn[0]), 1);
        chk("bust_out", int'(oc[0]), 2);
        chk("bust_req2", int'(req[0]), 0);
        @(negedge clk);
        chk("bust_done_end", int'(dn[0]), 0);

        reset_all();
        do_start(18);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("delay_req%0d", i), int'(req[0]), 1);
            start = (i == 1);
            @(negedge clk);
        end
        start = 1'b0;
        cv = 1'b1;
        card = 4'd0;
        @(negedge clk);
        cv = 1'b0;
        chk("zero_score", int'(ds[0]), 0);
        chk("zero_cnt", int'(cd[0]), 0);
        chk("zero_req", int'(req[0]), 1);
        cv = 1'b1;
        card = 4'd10;
        @(negedge clk);
        cv = 1'b0;
        card = 4'd0;
        chk("delay_score1", int'(ds[0]), 10);
        chk("delay_cnt1", int'(cd[0]), 1);
        feed(0, 7);
        wait_done(0);
        chk("delay_score", int'(ds[0]), 17);
        chk("delay_cnt", int'(cd[0]), 2);
        chk("delay_out", int'(oc[0]), 1);
        cv = 1'b1;
        card = 4'd5;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen |= int'(dn[0]) | int'(busy[0]);
        end
        cv = 1'b0;
        card = 4'd0;
        chk("hold_no_round", seen, 0);
        chk("hold_score", int'(ds[0]), 17);
        chk("hold_cnt", int'(cd[0]), 2);
        chk("hold_out", int'(oc[0]), 1);

        reset_all();
        do_start(20);
        for (int k = 0; k < 3; k++) feed(1, 1);
        wait_done(1);
        chk("max_score", int'(ds[1]), 3);
        chk("max_cnt", int'(cd[1]), 3);
        chk("max_out", int'(oc[1]), 1);

        reset_all();
        do_start(18);
        feed(0, 5);
        wait_req(0);
        @(negedge clk);
        chk("pre_rst_req", int'(req[0]), 1);
        chk("pre_rst_score", int'(ds[0]), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", int'(req[0]), 0);
        chk("arst_busy", int'(busy[0]), 0);
        chk("arst_done", int'(dn[0]), 0);
        chk("arst_score", int'(ds[0]), 0);
        chk("arst_cnt", int'(cd[0]), 0);
        chk("arst_out", int'(oc[0]), 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen |= int'(dn[0]);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            seen |= int'(dn[0]) | int'(busy[0]) | int'(req[0]);
        end
        chk("arst_no_done", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dealer_sequencer.md
DEALER_SEQUENCER -- requirements
Module: dealer_sequencer

Interface
REQ-001 Parameter STAND_AT, default 17: dealer stops drawing once dealer_score >= STAND_AT.
REQ-002 Parameter MAX_CARDS, default 7: hard cap on dealer draws per round.
REQ-003 clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle pulse; player has stood, dealer turn begins.
REQ-006 player_score  in  6  player total; must be held stable from start until done.
REQ-007 card_req  out  1  request to the shared card source.
REQ-008 card_valid  in  1  card source acknowledge; card is valid this cycle.
REQ-009 card  in  4  drawn card value, legal range 1..13.
REQ-010 dealer_score  out  6  running dealer total.
REQ-011 cards_drawn  out  3  number of cards accepted this round.
REQ-012 busy  out  1  high from the cycle after start until done.
REQ-013 done  out  1  single-cycle pulse; round result is final.
REQ-014 outcome  out  2  00 none, 01 player wins, 10 dealer wins, 11 push.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, CHECK, DONE.
REQ-016 IDLE: on start=1, clear dealer_score, cards_drawn and outcome; then go to DONE if player_score > 21, else go to REQ.
REQ-017 start received while not in IDLE SHALL be ignored.
REQ-018 REQ: drive card_req=1 and go to WAIT on the next cycle; card_req is high in the cycle after start (latency 1).
REQ-019 WAIT: hold card_req=1 until a cycle with card_valid=1.
REQ-020 In that cycle, add card to dealer_score, increment cards_drawn, drop card_req on the next cycle, and go to CHECK.
REQ-021 card=0 in WAIT SHALL be discarded: no score or count change, stay in WAIT, card_req stays high.
REQ-022 card_valid outside WAIT SHALL be ignored.
REQ-023 CHECK: go to REQ if dealer_score < STAND_AT and cards_drawn < MAX_CARDS; otherwise go to DONE.
REQ-024 DONE: set outcome, pulse done for one cycle, then return to IDLE.
REQ-025 Outcome rules, in priority order:
  - player_score > 21 -> 10
  - dealer_score > 21 -> 01
  - dealer_score > player_score -> 10
  - dealer_score = player_score -> 11
  - otherwise -> 01
REQ-026 outcome, dealer_score and cards_drawn SHALL hold their values in IDLE until the next accepted start.
REQ-027 dealer_score is 6-bit unsigned with no wrap: the maximum reachable total is 16+13=29.
REQ-028 cards_drawn SHALL never exceed MAX_CARDS.
REQ-029 busy SHALL be 1 in REQ, WAIT, CHECK and DONE, and 0 in IDLE.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, regardless of clock.
REQ-031 reset=0 SHALL immediately clear to 0: card_req, busy, done, outcome, dealer_score, cards_drawn.
REQ-032 Reset asserted mid-round, including in WAIT with card_req high, SHALL abandon the round with no done pulse.

Structure
REQ-033 Shared package game_pkg SHALL hold:
  - outcome codes OUT_NONE, OUT_PLAYER, OUT_DEALER, OUT_PUSH
  - BUST_LIMIT=21
  - score width 6 and card width 4
REQ-034 One combinational sub-module, score_judge (inputs player_score, dealer_score; output outcome), SHALL implement REQ-025.

Verification
REQ-035 Cards 10 then 7, player_score=18: card_req high cycle after start; dealer_score=17, cards_drawn=2, outcome=01, one done pulse.
REQ-036 player_score=22 with start: no card_req ever; outcome=10, done 2 cycles after start.
REQ-037 Cards 9, 4, 13, player_score=20: dealer_score=26, outcome=01.
REQ-038 Cards 10, 9 with player_score=19 gives outcome=11; same cards with player_score=18 gives outcome=10.
REQ-039 card_valid delayed 5 cycles, a card=0 offered, start repulsed mid-round: card_req held throughout; 0 discarded; second start ignored.
REQ-040 MAX_CARDS=3, cards 1,1,1: stops at cards_drawn=3, dealer_score=3; separately, reset in WAIT forces all outputs to 0 and no done pulse.
